// File: rtl/piso_tx4.sv
// rtl/piso_tx4.sv - 4-bit parallel-in serial-out transmitter with one-word holding buffer
module piso_tx4 #(
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [3:0] par_in,
  input  logic       load,
  output logic       ready,
  output logic       busy,
  output logic       ser_out,
  output logic       sh_ena,
  output logic       done
);
  localparam int DW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [3:0]    buf_q, buf_d;
  logic          buf_full_q, buf_full_d;
  logic [3:0]    sr_q, sr_d;
  logic [1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic          done_q, done_d;
  logic          bit_end, word_end;

  assign bit_end  = (state_q == SHIFT) && (div_q == DIV_LAST);
  assign word_end = bit_end && (bit_cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        IDLE:    if (buf_full_q) state_d = SHIFT;
        SHIFT:   if (word_end && !buf_full_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_q      <= 4'b0000;
      buf_full_q <= 1'b0;
      sr_q       <= 4'b0000;
      bit_cnt_q  <= 2'd0;
      div_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      div_q      <= div_d;
      done_q     <= done_d;
    end
  end

  // A word finishing with the buffer full reloads on the same edge, so there is no idle gap.
  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    done_d     = done_q;
    if (ena) begin
      done_d = 1'b0;
      if (state_q == IDLE) begin
        if (buf_full_q) begin
          sr_d       = buf_q;
          buf_full_d = 1'b0;
          bit_cnt_d  = 2'd0;
          div_d      = '0;
        end
      end else if (!bit_end) begin
        div_d = div_q + DW'(1);
      end else begin
        div_d     = '0;
        bit_cnt_d = bit_cnt_q + 2'd1;
        if (word_end) begin
          done_d     = 1'b1;
          sr_d       = buf_full_q ? buf_q : 4'b0000;
          buf_full_d = 1'b0;
        end else begin
          sr_d = MSB_FIRST ? {sr_q[2:0], 1'b0} : {1'b0, sr_q[3:1]};
        end
      end
      if (load && !buf_full_q) begin
        buf_d      = par_in;
        buf_full_d = 1'b1;
      end
    end
  end

  always_comb begin
    ready   = !buf_full_q;
    busy    = (state_q == SHIFT);
    ser_out = 1'b0;
    if (state_q == SHIFT) ser_out = MSB_FIRST ? sr_q[3] : sr_q[0];
    sh_ena  = ena && bit_end;
    done    = ena && done_q;
  end

endmodule

// File: tb/tb_piso_tx4.sv
// tb/tb_piso_tx4.sv - bench for piso_tx4; two instances (1 cycle/bit MSB-first, 3 cycles/bit LSB-first)
module tb_piso_tx4;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b1;
  logic       load = 1'b0;
  logic [3:0] par_in = 4'b0000;
  logic [1:0] rdy, bsy, ser, she, dn;

  int errors = 0;
  int checks = 0;

  bit         m_full [2];
  logic [3:0] m_buf  [2];
  logic [3:0] m_word [2];
  logic [3:0] m_last [2];
  int         m_rem  [2];
  bit         m_done [2];
  logic [3:0] rx     [2] = '{4'b0000, 4'b0000};

  always #5 clk = ~clk;

  piso_tx4 #(.BIT_CYCLES(1), .MSB_FIRST(1'b1)) u_tx1 (
    .clk(clk), .reset(reset), .ena(ena), .par_in(par_in), .load(load),
    .ready(rdy[0]), .busy(bsy[0]), .ser_out(ser[0]), .sh_ena(she[0]), .done(dn[0])
  );

  piso_tx4 #(.BIT_CYCLES(3), .MSB_FIRST(1'b0)) u_tx3 (
    .clk(clk), .reset(reset), .ena(ena), .par_in(par_in), .load(load),
    .ready(rdy[1]), .busy(bsy[1]), .ser_out(ser[1]), .sh_ena(she[1]), .done(dn[1])
  );

  function automatic int bc(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit msb(int i);
    return (i == 0);
  endfunction

  // Model: a word occupies 4*bc cycles; remaining-cycle count gives bit index and strobe position.
  function automatic logic [4:0] exp_vec(int i);
    int   el, k;
    logic s, sh;
    s  = 1'b0;
    sh = 1'b0;
    if (m_rem[i] > 0) begin
      el = 4 * bc(i) - m_rem[i];
      k  = el / bc(i);
      s  = msb(i) ? m_word[i][3-k] : m_word[i][k];
      sh = ena && ((el % bc(i)) == bc(i) - 1);
    end
    return {!m_full[i], m_rem[i] > 0, s, sh, ena && m_done[i]};
  endfunction

  function automatic logic [4:0] obs(int i);
    return {rdy[i], bsy[i], ser[i], she[i], dn[i]};
  endfunction

  task automatic model_edge(int i);
    bit rdy_pre;
    rdy_pre = !m_full[i];
    if (!reset) begin
      m_full[i] = 1'b0;
      m_rem[i]  = 0;
      m_done[i] = 1'b0;
    end else if (ena) begin
      m_done[i] = 1'b0;
      if (m_rem[i] > 0) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_done[i] = 1'b1;
          m_last[i] = m_word[i];
        end
      end
      if (m_rem[i] == 0 && m_full[i]) begin
        m_word[i] = m_buf[i];
        m_full[i] = 1'b0;
        m_rem[i]  = 4 * bc(i);
      end
      if (load && rdy_pre) begin
        m_buf[i]  = par_in;
        m_full[i] = 1'b1;
      end
    end
  endtask

  // Receivers sample ser_out on sh_ena, like a SIPO clocked by the same edge.
  task automatic tick();
    #1;
    for (int i = 0; i < 2; i++)
      if (she[i]) rx[i] = msb(i) ? {rx[i][2:0], ser[i]} : {ser[i], rx[i][3:1]};
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0; load = 1'b0; ena = 1'b1;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ena = 1'b0; load = 1'b1; par_in = 4'hF;
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== 5'b10000) begin
        errors++;
        $display("FAIL reset_ena0 inst%0d: got %b expected 10000", i, obs(i));
      end
    end
    ena = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== 5'b10000) begin
        errors++;
        $display("FAIL reset_load inst%0d: got %b expected 10000", i, obs(i));
      end
    end
    reset = 1'b1; load = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] sser;
    int nsh;
    sser = 4'b0000; nsh = 0;
    apply_reset();
    par_in = 4'b1011; load = 1'b1;
    tick();
    load = 1'b0; par_in = 4'($urandom);
    checks++;
    if (rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready inst0: got %b expected 0", rdy[0]);
    end
    for (int c = 1; c <= 6; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL basic_model inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
        end
      end
      if (c <= 4) begin
        sser[4-c] = ser[0];
        nsh += int'(she[0]);
      end
      if (c == 5) begin
        checks++;
        if ({dn[0], bsy[0]} !== 2'b10) begin
          errors++;
          $display("FAIL basic_done inst0: got done,busy=%b expected 10", {dn[0], bsy[0]});
        end
      end
    end
    checks++;
    if (sser !== 4'b1011 || nsh != 4) begin
      errors++;
      $display("FAIL basic_seq inst0: got bits %b strobes %0d expected 1011 and 4", sser, nsh);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_q [$];
    int ndone;
    exp_q = '{4'b1011, 4'b0110};
    ndone = 0;
    apply_reset();
    par_in = 4'b1011; load = 1'b1; tick();
    load = 1'b0; tick();
    par_in = 4'b0110; load = 1'b1; tick();
    par_in = 4'b1111; tick();
    load = 1'b0;
    for (int c = 0; c < 32; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL b2b_model inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
        end
      end
      if (dn[0]) begin
        checks++;
        if (ndone >= 2 || rx[0] !== exp_q[ndone] || (ndone == 0 && bsy[0] !== 1'b1)) begin
          errors++;
          $display("FAIL b2b_word inst0 #%0d: got rx=%b busy=%b expected %b busy=1", ndone, rx[0], bsy[0],
                   (ndone < 2) ? exp_q[ndone] : 4'bxxxx);
        end
        ndone++;
      end
      tick();
    end
    checks++;
    if (ndone != 2) begin
      errors++;
      $display("FAIL b2b_count inst0: got %0d words expected 2", ndone);
    end
  endtask

  task automatic test_slow();
    logic [12:0] m_sh, m_dn, m_ser;
    m_sh = '0; m_dn = '0; m_ser = '0;
    apply_reset();
    par_in = 4'b1000; load = 1'b1; tick();
    load = 1'b0; tick();
    for (int c = 1; c <= 13; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL slow_model inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
        end
      end
      m_sh[c-1] = she[1]; m_dn[c-1] = dn[1]; m_ser[c-1] = ser[1];
      tick();
    end
    checks++;
    if (m_sh !== 13'h0924 || m_dn !== 13'h1000 || m_ser !== 13'h0E00) begin
      errors++;
      $display("FAIL slow_timing inst1: got sh=%h done=%h ser=%h expected 0924 1000 0e00", m_sh, m_dn, m_ser);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    par_in = 4'b1101; load = 1'b1; tick();
    load = 1'b0; tick();
    par_in = 4'b0011; load = 1'b1; tick();
    load = 1'b0; reset = 1'b0; tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== 5'b10000) begin
        errors++;
        $display("FAIL midreset_out inst%0d: got %b expected 10000", i, obs(i));
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({dn[i], bsy[i]} !== 2'b00 || obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL midreset_after inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_ena_hold();
    apply_reset();
    par_in = 4'b0101; load = 1'b1; tick();
    load = 1'b0; tick(); tick();
    ena = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({ser[i], she[i], dn[i]} !== 3'b100 || obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL ena_hold inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
        end
      end
    end
    ena = 1'b1;
    tick();
    checks++;
    if ({ser[1], she[1]} !== 2'b11) begin
      errors++;
      $display("FAIL ena_resume inst1: got ser,sh=%b expected 11", {ser[1], she[1]});
    end
    for (int c = 0; c < 14; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL ena_model inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      ena    = ($urandom_range(0, 9) < 8);
      load   = ($urandom_range(0, 9) < 3);
      par_in = 4'($urandom);
      reset  = ($urandom_range(0, 199) != 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL rand_model inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
        end
        if (dn[i]) begin
          checks++;
          if (rx[i] !== m_last[i]) begin
            errors++;
            $display("FAIL rand_word inst%0d cyc%0d: got %b expected %b", i, c, rx[i], m_last[i]);
          end
        end
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_slow();
    test_reset_mid();
    test_ena_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
